// File: rtl/interval_timer_pkg.sv
// Shared constants for the interval timer and the time-parameter store:
// interval selector codes, timer state encoding and default counter width.
package interval_timer_pkg;

    localparam int CNT_W_DEFAULT = 4;

    localparam logic [1:0] SEL_BASE = 2'b00;
    localparam logic [1:0] SEL_EXT  = 2'b01;
    localparam logic [1:0] SEL_YEL  = 2'b10;
    localparam logic [1:0] SEL_DBL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_RUN  = 2'b11
    } timer_state_t;

endpackage

// File: rtl/interval_timer.sv
// Interval timer: fetches an interval length from the parameter store, counts
// it down on one-second ticks and pulses expired when it runs out.
module interval_timer
    import interval_timer_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             Reset_N,
    input  logic             start,
    input  logic [1:0]       interval_sel,
    input  logic             one_hz_enable,
    input  logic [CNT_W-1:0] value,
    output logic [1:0]       time_selector,
    output logic             busy,
    output logic             expired,
    output logic [CNT_W-1:0] remaining,
    output logic [1:0]       state_dbg
);

    // Handshake: start is a single-cycle request sampled on clk; there is no
    // ready. A start while busy aborts the running interval without expiry.

    timer_state_t     state, state_n;
    logic [1:0]       sel_n;
    logic             busy_n;
    logic             expired_n;
    logic [CNT_W-1:0] remaining_n;
    logic             final_tick;

    assign final_tick = one_hz_enable && (remaining == CNT_W'(1));
    assign state_dbg  = state;

    always_ff @(posedge clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state         <= ST_IDLE;
            time_selector <= SEL_BASE;
            busy          <= 1'b0;
            expired       <= 1'b0;
            remaining     <= '0;
        end else begin
            state         <= state_n;
            time_selector <= sel_n;
            busy          <= busy_n;
            expired       <= expired_n;
            remaining     <= remaining_n;
        end
    end

    always_comb begin
        state_n     = state;
        sel_n       = time_selector;
        busy_n      = busy;
        expired_n   = 1'b0;
        remaining_n = remaining;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    sel_n   = interval_sel;
                    busy_n  = 1'b1;
                    state_n = ST_REQ;
                end
            end

            ST_REQ: begin
                if (start) begin
                    sel_n       = interval_sel;
                    remaining_n = '0;
                    state_n     = ST_REQ;
                end else begin
                    state_n = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (start) begin
                    sel_n       = interval_sel;
                    remaining_n = '0;
                    state_n     = ST_REQ;
                end else begin
                    remaining_n = value;
                    if (value == '0) begin
                        expired_n = 1'b1;
                        busy_n    = 1'b0;
                        state_n   = ST_IDLE;
                    end else begin
                        state_n = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                if (final_tick) begin
                    // The interval completed, so expired fires even if a new
                    // start arrives on the same edge.
                    remaining_n = '0;
                    expired_n   = 1'b1;
                    if (start) begin
                        sel_n   = interval_sel;
                        state_n = ST_REQ;
                    end else begin
                        busy_n  = 1'b0;
                        state_n = ST_IDLE;
                    end
                end else if (start) begin
                    sel_n       = interval_sel;
                    remaining_n = '0;
                    state_n     = ST_REQ;
                end else if (one_hz_enable && (remaining != '0)) begin
                    remaining_n = remaining - CNT_W'(1);
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_interval_timer.sv
// Self-checking bench for interval_timer: directed vector table, hand-written
// corner sequences and randomized traffic against a behavioural model.
module tb_interval_timer;
    import interval_timer_pkg::*;

    localparam int W = 4;

    logic         clk;
    logic         Reset_N;
    logic         start;
    logic [1:0]   interval_sel;
    logic         one_hz_enable;
    logic [W-1:0] value;
    logic [1:0]   time_selector;
    logic         busy;
    logic         expired;
    logic [W-1:0] remaining;
    logic [1:0]   state_dbg;

    interval_timer #(.CNT_W(W)) dut (
        .clk           (clk),
        .Reset_N       (Reset_N),
        .start         (start),
        .interval_sel  (interval_sel),
        .one_hz_enable (one_hz_enable),
        .value         (value),
        .time_selector (time_selector),
        .busy          (busy),
        .expired       (expired),
        .remaining     (remaining),
        .state_dbg     (state_dbg)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // parameter store contents: base, ext, yel, 2*base (truncated)
    logic [W-1:0] store [4];

    // behavioural model: an interval is "active" from its start edge; the
    // length is loaded two edges later and ticks count only after that.
    bit       m_active;
    int       m_age;
    int       m_rem;
    bit       m_exp;
    bit [1:0] m_sel;

    typedef struct {
        bit       st;
        bit [1:0] sel;
        bit       tk;
        bit       e_busy;
        bit       e_exp;
        int       e_rem;
        bit [1:0] e_ts;
    } vec_t;

    vec_t vecs[$];

    function automatic void check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_active = 0;
        m_age    = 0;
        m_rem    = 0;
        m_exp    = 0;
        m_sel    = 2'b00;
    endfunction

    function automatic void model_edge(bit st, bit [1:0] sl, bit tk, int v);
        m_exp = 0;
        if (m_active && m_age >= 2 && tk) begin
            if (m_rem == 1) begin
                m_exp    = 1;
                m_rem    = 0;
                m_active = 0;
            end else if (m_rem > 0) begin
                m_rem = m_rem - 1;
            end
        end
        if (st) begin
            m_active = 1;
            m_age    = 0;
            m_sel    = sl;
            m_rem    = 0;
        end else if (m_active) begin
            m_age = m_age + 1;
            if (m_age == 2) begin
                m_rem = v;
                if (v == 0) begin
                    m_exp    = 1;
                    m_active = 0;
                end
            end
        end
    endfunction

    function automatic void check_model(string tag);
        check({tag, ".busy"}, int'(busy), int'(m_active));
        check({tag, ".expired"}, int'(expired), int'(m_exp));
        check({tag, ".remaining"}, int'(remaining), m_rem);
        check({tag, ".time_selector"}, int'(time_selector), int'(m_sel));
    endfunction

    // driver: apply inputs for one edge, then check #1 after it; the store
    // returns the selector it saw before the edge as a registered value
    task automatic step(input bit st, input bit [1:0] sl, input bit tk, input string tag);
        logic [1:0] ts_pre;
        start         = st;
        interval_sel  = sl;
        one_hz_enable = tk;
        ts_pre        = time_selector;
        if (Reset_N) model_edge(st, sl, tk, int'(value));
        else         model_reset();
        @(posedge clk);
        #1;
        value         = store[ts_pre];
        start         = 1'b0;
        one_hz_enable = 1'b0;
        check_model(tag);
    endtask

    // start an interval and tick with the given period; count ticks that
    // land after the load edge and the expired pulses seen
    task automatic run_interval(input bit [1:0] sl, input int period, input int phase,
                                input int exp_load, input int exp_ticks, input string tag);
        int counted;
        int pulses;
        bit tk;
        bit done;
        counted = 0;
        pulses  = 0;
        done    = 0;
        step(1'b1, sl, 1'b0, tag);
        check({tag, ".sel_latched"}, int'(time_selector), int'(sl));
        for (int k = 1; k < 400 && !done; k++) begin
            tk = ((k % period) == phase);
            step(1'b0, 2'b00, tk, tag);
            if (k == 2) check({tag, ".load"}, int'(remaining), exp_load);
            if (tk && k >= 3) counted++;
            if (expired) begin
                pulses++;
                check({tag, ".rem_at_expiry"}, int'(remaining), 0);
            end
            if (k > 2 && !busy) done = 1;
        end
        check({tag, ".finished_in_budget"}, int'(done), 1);
        check({tag, ".ticks_counted"}, counted, exp_ticks);
        check({tag, ".expired_pulses"}, pulses, 1);
        step(1'b0, 2'b00, 1'b0, tag);
        check({tag, ".idle_busy"}, int'(busy), 0);
    endtask

    task automatic add_vec(bit st, bit [1:0] sel, bit tk, bit eb, bit ee, int er, bit [1:0] ets);
        vec_t v;
        v.st = st; v.sel = sel; v.tk = tk;
        v.e_busy = eb; v.e_exp = ee; v.e_rem = er; v.e_ts = ets;
        vecs.push_back(v);
    endtask

    initial begin
        store[0] = 4'd6;
        store[1] = 4'd3;
        store[2] = 4'd2;
        store[3] = 4'd12;
        start = 0; interval_sel = 0; one_hz_enable = 0; value = 0;
        model_reset();

        Reset_N = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.busy", int'(busy), 0);
        check("reset.expired", int'(expired), 0);
        check("reset.remaining", int'(remaining), 0);
        check("reset.time_selector", int'(time_selector), 0);
        check("reset.state", int'(state_dbg), int'(ST_IDLE));
        Reset_N = 1'b1;
        step(1'b0, 2'b00, 1'b1, "idle");

        // yel interval with ticks during load, start on its final tick,
        // abort of the base interval, then a full ext interval
        add_vec(1, SEL_YEL,  0, 1, 0, 0, SEL_YEL);
        add_vec(0, 0,        1, 1, 0, 0, SEL_YEL);
        add_vec(0, 0,        1, 1, 0, 2, SEL_YEL);
        add_vec(0, 0,        0, 1, 0, 2, SEL_YEL);
        add_vec(0, 0,        1, 1, 0, 1, SEL_YEL);
        add_vec(1, SEL_BASE, 1, 1, 1, 0, SEL_BASE);
        add_vec(0, 0,        0, 1, 0, 0, SEL_BASE);
        add_vec(0, 0,        0, 1, 0, 6, SEL_BASE);
        add_vec(1, SEL_EXT,  1, 1, 0, 0, SEL_EXT);
        add_vec(0, 0,        0, 1, 0, 0, SEL_EXT);
        add_vec(0, 0,        0, 1, 0, 3, SEL_EXT);
        add_vec(0, 0,        1, 1, 0, 2, SEL_EXT);
        add_vec(0, 0,        1, 1, 0, 1, SEL_EXT);
        add_vec(0, 0,        1, 0, 1, 0, SEL_EXT);
        add_vec(0, 0,        1, 0, 0, 0, SEL_EXT);
        foreach (vecs[i]) begin
            step(vecs[i].st, vecs[i].sel, vecs[i].tk, "vec");
            check($sformatf("vec%0d.busy", i), int'(busy), int'(vecs[i].e_busy));
            check($sformatf("vec%0d.expired", i), int'(expired), int'(vecs[i].e_exp));
            check($sformatf("vec%0d.remaining", i), int'(remaining), vecs[i].e_rem);
            check($sformatf("vec%0d.time_selector", i), int'(time_selector), int'(vecs[i].e_ts));
        end

        run_interval(SEL_BASE, 10, 9, 6, 6, "base");
        run_interval(SEL_YEL, 4, 2, 2, 2, "yel");
        run_interval(SEL_DBL, 3, 2, 12, 12, "dbl");

        // zero-length interval expires straight from the load edge
        store[1] = 4'd0;
        step(1'b1, SEL_EXT, 1'b0, "zero");
        step(1'b0, 2'b00, 1'b0, "zero");
        check("zero.busy_before", int'(busy), 1);
        step(1'b0, 2'b00, 1'b1, "zero");
        check("zero.expired", int'(expired), 1);
        check("zero.busy", int'(busy), 0);
        check("zero.remaining", int'(remaining), 0);
        step(1'b0, 2'b00, 1'b0, "zero");
        check("zero.pulse_width", int'(expired), 0);
        store[1] = 4'd3;

        // asynchronous reset in the middle of a base interval at remaining=4
        step(1'b1, SEL_BASE, 1'b0, "arst");
        step(1'b0, 2'b00, 1'b0, "arst");
        step(1'b0, 2'b00, 1'b0, "arst");
        step(1'b0, 2'b00, 1'b1, "arst");
        step(1'b0, 2'b00, 1'b1, "arst");
        check("arst.rem_before", int'(remaining), 4);
        #2;
        Reset_N = 1'b0;
        #1;
        check("arst.busy", int'(busy), 0);
        check("arst.expired", int'(expired), 0);
        check("arst.remaining", int'(remaining), 0);
        check("arst.time_selector", int'(time_selector), 0);
        model_reset();
        step(1'b0, 2'b00, 1'b1, "arst_hold");
        Reset_N = 1'b1;
        for (int k = 0; k < 5; k++) step(1'b0, 2'b00, 1'b1, "arst_idle");
        check("arst.stays_idle", int'(state_dbg), int'(ST_IDLE));

        // randomized traffic against the model
        for (int k = 0; k < 1500; k++) begin
            if ((k % 60) == 0) begin
                for (int j = 0; j < 4; j++) store[j] = 4'($urandom_range(0, 15));
            end
            step(($urandom_range(0, 19) == 0), 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 2) == 0), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/interval_timer.md
Name: interval_timer

Overview:
Consumer end of the time-parameter interface. On a start request it drives time_selector to the parameter store and captures the returned registered value. It then counts that many one-second ticks and pulses expired when the interval ends. The traffic-light FSM uses it for every base, extended, yellow and double-base interval; remaining also feeds the countdown display.

Parameters:
CNT_W, 4, width of value/remaining; must equal the parameter store's value width.

Ports:
clk  input  1  system clock, rising edge
Reset_N  input  1  asynchronous, active-low reset
start  input  1  single-cycle request to begin an interval; sampled on clk
interval_sel  input  2  interval kind: 00 base, 01 ext, 10 yel, 11 2*base; sampled when start=1
one_hz_enable  input  1  one-cycle-wide strobe, once per second, from divider
value  input  CNT_W  registered interval length returned by the parameter store
time_selector  output  2  selector driven to the parameter store
busy  output  1  high from the cycle after start until the cycle expired is asserted
expired  output  1  one-cycle pulse at end of interval
remaining  output  CNT_W  seconds left; 0 when idle

Behaviour:
- Reset (Reset_N=0, async, any state): state=IDLE, time_selector=00, busy=0, expired=0, remaining=0. Release is clean mid-interval; no expiry is generated for an aborted interval.
- States: IDLE, REQ, WAIT, RUN (2-bit encoding).
- IDLE: start=1 -> latch interval_sel into time_selector, busy=1, go REQ.
- REQ: one cycle. The store samples time_selector on this edge -> WAIT.
- WAIT: one cycle. At the closing edge, capture remaining<=value.
  - value!=0 -> RUN.
  - value==0 -> assert expired next cycle, busy=0, go IDLE.
- Load latency: start sampled at edge E0 -> value captured at E2 -> first decrement possible at E3.
- RUN: each cycle with one_hz_enable=1 -> remaining<=remaining-1.
  - When remaining==1 and tick: remaining<=0, expired=1 for exactly one cycle, busy=0, go IDLE.
- one_hz_enable is ignored in IDLE, REQ and WAIT. A tick coincident with the capture edge is not counted.
- time_selector holds its last value after expiry until the next start.
- start while busy (REQ/WAIT/RUN): abort the current interval with no expired pulse. Relatch interval_sel, go REQ.
- start in the same cycle as the final tick: expired still pulses (interval completed). Next state is REQ with the new selector; busy stays 1.
- Width: value is CNT_W bits. 2*base is already truncated to CNT_W by the store; the timer does not extend it and counts the truncated value.
- remaining never wraps below 0; decrement only in RUN with remaining>=1.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package: interval selector constants SEL_BASE=2'b00, SEL_EXT=2'b01, SEL_YEL=2'b10, SEL_DBL=2'b11.
- Shared package: timer state encoding and default CNT_W; the parameter store imports the same selector constants.
- No sub-module; the single FSM plus down-counter is natural as one block.

Test Plan:
- Reset with the store at defaults (6/3/2): start, sel=00, ticks every 10 cycles -> time_selector=00 at E1, remaining=6 at E2, decrements 5..1,0; one expired pulse coincident with remaining=0; busy low after.
- sel=10 (yel=2) and sel=11 (2*base=12) -> expired after exactly 2 and 12 ticks; ticks during REQ/WAIT not counted.
- Store value programmed to 0, start sel=01 -> expired pulses 3 cycles after start, no RUN state, remaining=0.
- Start sel=00, then start sel=10 after 3 ticks -> no expired for the first interval; remaining reloads to 2 and expires after 2 ticks.
- Start asserted on the same cycle as the final tick of a yel interval -> expired=1 that cycle, busy stays 1, time_selector switches to the new sel, new interval loads.
- Drop Reset_N asynchronously mid-RUN (remaining=4) -> all outputs 0 immediately, no expired; after release, idle until start.
